// File: rtl/sub_rr_scheduler.sv
// sub_rr_scheduler: round-robin arbiter sharing one WIDTH-bit subtractor
// between NUM_REQ requesters, with a single-entry tagged result register.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid/_a/_b  per-requester operand pairs (packed i*WIDTH +: WIDTH)
//   req_ready        one-hot grant, combinational
//   rsp_valid/ready  output register handshake
//   rsp_result       a - b (wrapping, or unsigned-saturating)
//   rsp_borrow       a < b unsigned
//   rsp_ovf          signed overflow of a - b
//   rsp_id           requester index of the held result
//   op_count         saturating count of completed rsp handshakes
//
// Build option: define SUB_SAT_EN to clamp rsp_result to 0 on borrow.
module sub_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_borrow,
  output logic                       rsp_ovf,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [CNT_W-1:0]           op_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = IDW + 1;

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic             ovf_q, ovf_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hit;
  logic [IDW-1:0]   gid;
  logic [SW-1:0]    idx;
  logic             slot_free;
  logic             gnt;
  logic             fire;

  logic [WIDTH-1:0] a_g, b_g;
  logic [WIDTH:0]   diff;
  logic             brw;
  logic             ovf;
  logic [WIDTH-1:0] res;

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    hit = 1'b0;
    gid = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + SW'(k);
      if (idx >= SW'(NUM_REQ)) idx = idx - SW'(NUM_REQ);
      if (!hit && req_valid[idx[IDW-1:0]]) begin
        hit = 1'b1;
        gid = idx[IDW-1:0];
      end
    end
  end

  assign slot_free = !vld_q || rsp_ready;
  assign gnt       = slot_free && hit && !rst;
  assign fire      = vld_q && rsp_ready;
  assign req_ready = gnt ? (NUM_REQ'(1) << gid) : '0;

  always_comb begin
    a_g = '0;
    b_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid == IDW'(i)) begin
        a_g = req_a[i*WIDTH +: WIDTH];
        b_g = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Extra top bit of the difference is the unsigned borrow.
  assign diff = {1'b0, a_g} - {1'b0, b_g};
  assign brw  = diff[WIDTH];
  assign ovf  = (a_g[WIDTH-1] != b_g[WIDTH-1]) &&
                (diff[WIDTH-1] != a_g[WIDTH-1]);

`ifdef SUB_SAT_EN
  assign res = brw ? '0 : diff[WIDTH-1:0];
`else
  assign res = diff[WIDTH-1:0];
`endif

  // A drain and a new grant in the same cycle reload the register.
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    brw_d = brw_q;
    ovf_d = ovf_q;
    id_d  = id_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (fire) vld_d = 1'b0;
    if (gnt) begin
      vld_d = 1'b1;
      res_d = res;
      brw_d = brw;
      ovf_d = ovf;
      id_d  = gid;
      ptr_d = (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + IDW'(1);
    end
    if (fire && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
      brw_q <= 1'b0;
      ovf_q <= 1'b0;
      id_q  <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      brw_q <= brw_d;
      ovf_q <= ovf_d;
      id_q  <= id_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rsp_valid  = vld_q;
  assign rsp_result = res_q;
  assign rsp_borrow = brw_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_id     = id_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_sub_rr_scheduler.sv
// tb_sub_rr_scheduler: scoreboard bench for sub_rr_scheduler.
// Directed plan cases followed by randomized traffic.
module tb_sub_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_borrow;
  logic           rsp_ovf;
  logic [1:0]     rsp_id;
  logic [CW-1:0]  op_count;

  sub_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_borrow(rsp_borrow),
    .rsp_ovf(rsp_ovf), .rsp_id(rsp_id), .op_count(op_count)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       brw;
    logic       ovf;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ptr = 0;
  int   exp_cnt = 0;
  bit   pend[N];
  int   pa[N];
  int   pb[N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic straight from the rules.
  function automatic exp_t model(int a, int b, int g);
    exp_t e;
    int d, sa, sbv, sd;
    d     = a - b;
    e.brw = (d < 0);
    e.res = 8'((d + 256) % 256);
    sa    = (a >= 128) ? a - 256 : a;
    sbv   = (b >= 128) ? b - 256 : b;
    sd    = sa - sbv;
    e.ovf = (sd < -128) || (sd > 127);
`ifdef SUB_SAT_EN
    if (d < 0) e.res = 8'd0;
`endif
    e.id  = 2'(g);
    return e;
  endfunction

  task automatic load(int i, int a, int b);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic rdy, input bit keep = 1'b0);
    int g;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pend[i];
      req_a[i*W +: W]  = 8'(pa[i]);
      req_b[i*W +: W]  = 8'(pb[i]);
    end
    rsp_ready = rdy;
    #1;
    g = -1;
    if (!rst && (sb.size() == 0 || rdy)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (g < 0 && pend[j]) g = j;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      sb.push_back(model(pa[g], pb[g], g));
      ptr = (g + 1) % N;
      if (!keep) pend[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    sb.delete();
    ptr = 0;
    exp_cnt = 0;
    repeat (n) step(1'b0);
    rst = 1'b0;
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: one tick before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
          end else begin
            chk("rsp", {20'd0, rsp_result, rsp_borrow, rsp_ovf, rsp_id},
                32'(sb[0]));
            if (rsp_ready) begin
              void'(sb.pop_front());
              if (exp_cnt < (1 << CW) - 1) exp_cnt++;
            end
          end
        end else if (sb.size() != 0) begin
          chk("rsp_valid", 32'(rsp_valid), 32'd1);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    clear_all();
    for (int i = 0; i < N; i++) begin
      pa[i] = 0;
      pb[i] = 0;
    end
    @(negedge clk);

    // Reset and idle
    do_reset(2);
    repeat (2) step(1'b1);

    // Single requester
    load(1, 3, 1);
    repeat (3) step(1'b1);

    // Round robin, continuous requests
    do_reset(1);
    load(0, 76, 21);
    load(1, 49, 24);
    load(2, 113, 57);
    load(3, 97, 33);
    repeat (8) step(1'b1, 1'b1);
    clear_all();
    repeat (2) step(1'b1);

    // Backpressure
    do_reset(1);
    load(0, 14, 7);
    load(2, 12, 5);
    repeat (6) step(1'b0);
    repeat (3) step(1'b1);

    // Borrow and overflow corners
    load(0, 8'hF8, 8'h02);
    step(1'b1);
    load(1, 8'h80, 8'h01);
    step(1'b1);
    load(2, 8'h01, 8'h03);
    step(1'b1);
    load(3, 8'h7F, 8'hFF);
    step(1'b1);
    repeat (2) step(1'b1);

    // Reset while a result is held
    load(0, 5, 1);
    repeat (3) step(1'b0);
    load(1, 9, 4);
    load(3, 2, 8);
    do_reset(1);
    repeat (4) step(1'b1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) load(i, pick(), pick());
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    clear_all();
    repeat (4) step(1'b1);
    chk("drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
